// File: rtl/shift_arbiter_if.sv
// Handshake bundle between two shift requesters, the consumer and shift_arbiter.
// Latency: none, wiring only.
// Backpressure: req*_ready gates each requester, rsp_ready stalls the response.
interface shift_arbiter_if #(
    parameter int N = 32
);
    localparam int SW = $clog2(N);

    logic          req0_valid;
    logic          req0_ready;
    logic [N-1:0]  req0_in;
    logic [SW-1:0] req0_shamt;
    logic [1:0]    req0_op;

    logic          req1_valid;
    logic          req1_ready;
    logic [N-1:0]  req1_in;
    logic [SW-1:0] req1_shamt;
    logic [1:0]    req1_op;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [N-1:0]  rsp_data;
    logic          rsp_id;

    // Requesters and the result consumer.
    modport master (
        output req0_valid, req0_in, req0_shamt, req0_op,
        input  req0_ready,
        output req1_valid, req1_in, req1_shamt, req1_op,
        input  req1_ready,
        input  rsp_valid, rsp_data, rsp_id,
        output rsp_ready
    );

    // The arbiter.
    modport slave (
        input  req0_valid, req0_in, req0_shamt, req0_op,
        output req0_ready,
        input  req1_valid, req1_in, req1_shamt, req1_op,
        output req1_ready,
        output rsp_valid, rsp_data, rsp_id,
        input  rsp_ready
    );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin front-end for one shared 32-bit left shifter (right shifts via SHIFT_ARBITER_RIGHT_EN).
// Latency: handshake at edge t, registered result with rsp_valid seen at edge t+2; one job per 3 cycles.
// Backpressure: DONE holds outputs while rsp_ready=0; no requester is ready outside IDLE.
module shift_arbiter #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    shift_arbiter_if.slave bus,
    output logic           busy
);
    localparam int SW = $clog2(N);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    typedef struct packed {
        logic [N-1:0]  data;
        logic [SW-1:0] shamt;
        logic          id;
    } job_t;

    state_t       state;
    state_t       state_nxt;
    logic         last_grant;
    logic         gnt0;
    logic         gnt1;
    job_t         job0;
    job_t         job1;
    job_t         opr;
    logic [N-1:0] sh_res;

    assign job0 = '{data: bus.req0_in, shamt: bus.req0_shamt, id: 1'b0};
    assign job1 = '{data: bus.req1_in, shamt: bus.req1_shamt, id: 1'b1};

    // Pick a requester: a lone valid wins, a tie goes to whoever did not win last time.
    always_comb begin
        gnt0 = bus.req0_valid && (!bus.req1_valid || last_grant);
        gnt1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
    end

    // Next state plus handshake/status outputs; ready only ever leaves IDLE.
    always_comb begin
        state_nxt      = state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp_valid  = 1'b0;
        busy           = 1'b1;
        case (state)
            IDLE: begin
                busy           = 1'b0;
                bus.req0_ready = gnt0;
                bus.req1_ready = gnt1;
                if (gnt0 || gnt1) state_nxt = SHIFT;
            end
            SHIFT: state_nxt = DONE;
            DONE: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

`ifdef SHIFT_ARBITER_RIGHT_EN
    logic [1:0] opr_op;

    function automatic logic [N-1:0] bit_rev(input logic [N-1:0] v);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = v[N-1-i];
        return r;
    endfunction

    // Right shifts run through the left shifter on bit-reversed data; SRA ORs the sign into the vacated bits.
    always_comb begin
        logic         is_right;
        logic [N-1:0] sh_in;
        logic [N-1:0] sh_raw;
        logic [N-1:0] fill;
        is_right = (opr_op == 2'b01) || (opr_op == 2'b10);
        sh_in    = is_right ? bit_rev(opr.data) : opr.data;
        sh_raw   = sh_in << opr.shamt;
        fill     = ((opr_op == 2'b10) && opr.data[N-1]) ? ~({N{1'b1}} << opr.shamt) : '0;
        sh_res   = is_right ? bit_rev(sh_raw | fill) : sh_raw;
    end
`else
    // Op code is ignored in this build; keep it visibly consumed.
    logic unused_op;
    assign unused_op = ^{bus.req0_op, bus.req1_op};

    // Every job is a plain logical left shift.
    always_comb begin
        sh_res = opr.data << opr.shamt;
    end
`endif

    // Capture the winner's operands on the handshake and remember who won.
    always_ff @(posedge clk) begin
        if (rst) begin
            opr        <= '0;
            last_grant <= 1'b1;
`ifdef SHIFT_ARBITER_RIGHT_EN
            opr_op     <= 2'b00;
`endif
        end else if (state == IDLE && (gnt0 || gnt1)) begin
            opr        <= gnt0 ? job0 : job1;
            last_grant <= gnt1;
`ifdef SHIFT_ARBITER_RIGHT_EN
            opr_op     <= gnt0 ? bus.req0_op : bus.req1_op;
`endif
        end
    end

    // Register the shifter output and its owner; held untouched through DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_data <= '0;
            bus.rsp_id   <= 1'b0;
        end else if (state == SHIFT) begin
            bus.rsp_data <= sh_res;
            bus.rsp_id   <= opr.id;
        end
    end
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a job-level reference model checked every cycle.
// Latency: n/a.
// Backpressure: exercises rsp_ready stalls and simultaneous request/response.
module tb_shift_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    shift_arbiter_if #(.N(32)) bus ();

    shift_arbiter #(.N(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Arithmetic definition of each operation.
    function automatic logic [31:0] ref_shift(input logic [31:0] v, input logic [4:0] s, input logic [1:0] op);
        logic [31:0] r;
        r = v << s;
`ifdef SHIFT_ARBITER_RIGHT_EN
        if (op == 2'b01)      r = v >> s;
        else if (op == 2'b10) r = $signed(v) >>> s;
`else
        if (op == 2'b11) r = v << s;
`endif
        return r;
    endfunction

    // Job-level model: at most one job in flight, aged in cycles since acceptance.
    logic        m_init = 1'b0;
    logic        m_active = 1'b0;
    int          m_age = 0;
    logic        m_last = 1'b1;
    logic [31:0] m_res = '0;
    logic        m_id = 1'b0;
    logic [31:0] m_rsp_data = '0;
    logic        m_rsp_id = 1'b0;

    always @(negedge clk) begin
        logic e0;
        logic e1;
        e0 = !m_active && bus.req0_valid && (!bus.req1_valid || m_last);
        e1 = !m_active && bus.req1_valid && (!bus.req0_valid || !m_last);
        if (m_init) begin
            chk1("busy", busy, m_active);
            chk1("rsp_valid", bus.rsp_valid, m_active && m_age >= 1);
            chk32("rsp_data", bus.rsp_data, m_rsp_data);
            chk1("rsp_id", bus.rsp_id, m_rsp_id);
            chk1("req0_ready", bus.req0_ready, e0);
            chk1("req1_ready", bus.req1_ready, e1);
            chk1("one_ready", bus.req0_ready & bus.req1_ready, 1'b0);
        end
        if (rst) begin
            m_init = 1'b1; m_active = 1'b0; m_age = 0; m_last = 1'b1;
            m_rsp_data = '0; m_rsp_id = 1'b0;
        end else if (m_init) begin
            if (!m_active) begin
                if (e0) begin
                    m_res = ref_shift(bus.req0_in, bus.req0_shamt, bus.req0_op);
                    m_id = 1'b0; m_last = 1'b0; m_active = 1'b1; m_age = 0;
                end else if (e1) begin
                    m_res = ref_shift(bus.req1_in, bus.req1_shamt, bus.req1_op);
                    m_id = 1'b1; m_last = 1'b1; m_active = 1'b1; m_age = 0;
                end
            end else if (m_age == 0) begin
                m_rsp_data = m_res; m_rsp_id = m_id; m_age = 1;
            end else if (bus.rsp_ready) begin
                m_active = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic id, input logic v, input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
        if (id == 1'b0) begin
            bus.req0_valid = v; bus.req0_in = d; bus.req0_shamt = s; bus.req0_op = op;
        end else begin
            bus.req1_valid = v; bus.req1_in = d; bus.req1_shamt = s; bus.req1_op = op;
        end
    endtask

    task automatic reset_dut();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Wait (bounded) for the given requester's ready at a negedge; the next posedge is the handshake.
    task automatic wait_ready(input logic id, input string name);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = (id == 1'b0) ? bus.req0_ready : bus.req1_ready;
        end
        chk1({name, "_ready_seen"}, seen, 1'b1);
    endtask

    // One job from a single requester with rsp_ready high; checks latency and the literal result.
    task automatic do_job(input logic id, input logic [31:0] d, input logic [4:0] s,
                          input logic [1:0] op, input logic [31:0] exp, input string name);
        tick();
        set_req(id, 1'b1, d, s, op);
        wait_ready(id, name);
        tick();
        set_req(id, 1'b0, 32'h0, 5'd0, 2'b00);
        @(negedge clk);
        chk1({name, "_valid_t1"}, bus.rsp_valid, 1'b0);
        @(negedge clk);
        chk1({name, "_valid_t2"}, bus.rsp_valid, 1'b1);
        chk32({name, "_data"}, bus.rsp_data, exp);
        chk1({name, "_id"}, bus.rsp_id, id);
    endtask

    logic        ids[$];
    logic [31:0] datas[$];
    int          stamps[$];
    logic        exp_ids[3]   = '{1'b0, 1'b1, 1'b0};
    logic [31:0] exp_datas[3] = '{32'h0000_0010, 32'h0000_0300, 32'h0000_0010};

    initial begin
        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        set_req(1'b0, 1'b0, 32'h0, 5'd0, 2'b00);
        set_req(1'b1, 1'b0, 32'h0, 5'd0, 2'b00);
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_rsp_valid", bus.rsp_valid, 1'b0);
        chk32("reset_rsp_data", bus.rsp_data, 32'h0);

        // Single requester, top-bit shift.
        do_job(1'b0, 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, "sll31");

        // Tie, both held valid: req0, req1, req0, one result every 3 cycles.
        reset_dut();
        set_req(1'b0, 1'b1, 32'h0000_0001, 5'd4, 2'b00);
        set_req(1'b1, 1'b1, 32'h0000_0003, 5'd8, 2'b00);
        for (int c = 0; c < 30 && ids.size() < 3; c++) begin
            @(negedge clk);
            if (bus.rsp_valid && bus.rsp_ready) begin
                ids.push_back(bus.rsp_id);
                datas.push_back(bus.rsp_data);
                stamps.push_back(cyc);
            end
        end
        tick();
        set_req(1'b0, 1'b0, 32'h0, 5'd0, 2'b00);
        set_req(1'b1, 1'b0, 32'h0, 5'd0, 2'b00);
        chk32("tie_count", 32'(ids.size()), 32'd3);
        for (int i = 0; i < ids.size() && i < 3; i++) begin
            chk1($sformatf("tie_id%0d", i), ids[i], exp_ids[i]);
            chk32($sformatf("tie_data%0d", i), datas[i], exp_datas[i]);
        end
        for (int i = 1; i < stamps.size(); i++)
            chk32($sformatf("tie_gap%0d", i), 32'(stamps[i] - stamps[i-1]), 32'd3);
        repeat (4) tick();

        // Back-pressure: DONE held 10 cycles while req0 waits.
        bus.rsp_ready = 1'b0;
        tick();
        set_req(1'b1, 1'b1, 32'h0000_00A5, 5'd1, 2'b00);
        wait_ready(1'b1, "bp");
        tick();
        set_req(1'b1, 1'b0, 32'h0, 5'd0, 2'b00);
        set_req(1'b0, 1'b1, 32'h0000_0001, 5'd1, 2'b00);
        begin
            logic seen;
            seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clk);
                seen = bus.rsp_valid;
            end
            chk1("bp_valid_seen", seen, 1'b1);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk32("bp_hold_data", bus.rsp_data, 32'h0000_014A);
            chk1("bp_hold_busy", busy, 1'b1);
            chk1("bp_hold_r0", bus.req0_ready, 1'b0);
            chk1("bp_hold_r1", bus.req1_ready, 1'b0);
        end
        tick();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk1("bp_release_valid", bus.rsp_valid, 1'b1);
        chk1("bp_no_same_cycle_grant", bus.req0_ready, 1'b0);
        tick();
        @(negedge clk);
        chk1("bp_idle_busy", busy, 1'b0);
        chk1("bp_next_grant", bus.req0_ready, 1'b1);
        tick();
        set_req(1'b0, 1'b0, 32'h0, 5'd0, 2'b00);
        @(negedge clk);
        chk1("bp_next_shift", busy, 1'b1);
        @(negedge clk);
        chk32("bp_next_data", bus.rsp_data, 32'h0000_0002);
        chk1("bp_next_id", bus.rsp_id, 1'b0);

        // Operation encodings.
`ifdef SHIFT_ARBITER_RIGHT_EN
        do_job(1'b0, 32'h8000_00F0, 5'd4, 2'b01, 32'h0800_000F, "srl4");
        do_job(1'b1, 32'h8000_00F0, 5'd4, 2'b10, 32'hF800_000F, "sra4");
        do_job(1'b0, 32'h8000_00F0, 5'd0, 2'b00, 32'h8000_00F0, "sll0");
        do_job(1'b1, 32'h8000_00F0, 5'd0, 2'b01, 32'h8000_00F0, "srl0");
        do_job(1'b0, 32'h8000_00F0, 5'd0, 2'b10, 32'h8000_00F0, "sra0");
        do_job(1'b1, 32'h7000_0F00, 5'd8, 2'b10, 32'h0070_000F, "sra_pos");
        do_job(1'b0, 32'h8000_00F0, 5'd4, 2'b11, 32'h0000_0F00, "rsvd");
`else
        do_job(1'b0, 32'h8000_00F0, 5'd4, 2'b10, 32'h0000_0F00, "sra_as_sll");
        do_job(1'b1, 32'h8000_00F0, 5'd4, 2'b01, 32'h0000_0F00, "srl_as_sll");
        do_job(1'b0, 32'h8000_00F0, 5'd0, 2'b10, 32'h8000_00F0, "sra0");
`endif

        // Reset while in SHIFT after a req0 win; a following tie must go to req0.
        tick();
        set_req(1'b0, 1'b1, 32'h1234_5678, 5'd4, 2'b00);
        wait_ready(1'b0, "mid_rst");
        tick();
        set_req(1'b0, 1'b0, 32'h0, 5'd0, 2'b00);
        rst = 1'b1;
        @(negedge clk);
        chk1("mid_rst_in_shift", busy, 1'b1);
        tick();
        rst = 1'b0;
        set_req(1'b0, 1'b1, 32'h0000_0005, 5'd2, 2'b00);
        set_req(1'b1, 1'b1, 32'h0000_0007, 5'd3, 2'b00);
        @(negedge clk);
        chk1("mid_rst_valid", bus.rsp_valid, 1'b0);
        chk32("mid_rst_data", bus.rsp_data, 32'h0);
        chk1("mid_rst_busy", busy, 1'b0);
        chk1("mid_rst_tie_r0", bus.req0_ready, 1'b1);
        chk1("mid_rst_tie_r1", bus.req1_ready, 1'b0);
        tick();
        set_req(1'b0, 1'b0, 32'h0, 5'd0, 2'b00);
        set_req(1'b1, 1'b0, 32'h0, 5'd0, 2'b00);
        @(negedge clk);
        @(negedge clk);
        chk32("mid_rst_after_data", bus.rsp_data, 32'h0000_0014);
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (errors=%0d)", errors);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Sequencing front-end for the shared 32-bit logical left shifter. Two requesters (e.g. ALU and address-generation path) issue shift jobs over valid/ready handshakes. The arbiter grants one requester round-robin and registers operands into the single shifter instance. It returns the registered result with the winner's ID and holds it until the consumer accepts. Optional right-shift support reuses the same left shifter through bit reversal.

## Interface
- N, 32: datapath width; only N=32 is supported; shamt width is $clog2(N)=5.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- req0_valid / req1_valid  input  1  requester has a job.
- req0_ready / req1_ready  output  1  job accepted on this edge when valid&ready.
- req0_in / req1_in  input  N  operand.
- req0_shamt / req1_shamt  input  5  shift amount 0..31.
- req0_op / req1_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 reserved (treated as SLL).
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_data  output  N  shifted result.
- rsp_id  output  1  requester that issued the job (0/1).
- busy  output  1  high whenever state != IDLE.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Grant is combinational; req_ready is asserted only to the granted requester, and only in IDLE.
  - If one valid, grant it. If both valid, grant the one not granted last (last_grant register).
  - On handshake, capture in, shamt, op and id into operand registers; update last_grant; go to SHIFT.
- SHIFT:
  - Operand registers drive the shifter. For SRL/SRA the input is bit-reversed before the shifter and the output is reversed after it.
  - For SRA, the top shamt bits are forced to operand bit N-1.
  - On the next edge, capture the result into rsp_data; go to DONE.
- DONE:
  - rsp_valid=1; rsp_data and rsp_id are stable.
  - When rsp_ready, go to IDLE. No new grant is made in the same cycle.
- Result is bit-exact: SLL = in<<shamt, SRL = in>>shamt, SRA = $signed(in)>>>shamt. shamt=0 returns in unchanged for all ops.
- Requests that arrive while busy are not accepted. Requesters must hold valid and payload stable until ready.

## Timing
- Reset values: state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, last_grant=1 (so req0 wins the first tie), operand registers=0. req*_ready follow the grant logic in IDLE, i.e. they may be high right after reset.
- Latency: handshake at edge t → rsp_valid high from edge t+2.
- Throughput: at most one job per 3 cycles with rsp_ready tied high.
- Back-pressure: DONE persists indefinitely while rsp_ready=0, with no change in outputs.
- Reset mid-operation (SHIFT or DONE): the job is dropped, outputs return to reset values on that edge, and last_grant resets to 1.
- Simultaneous rsp_ready and new request in DONE: only the response completes. The request is granted the following cycle in IDLE.
- Only one req_ready is high in any cycle, and none while busy.

## Configuration
- SHIFT_ARBITER_RIGHT_EN defined: SRL/SRA are supported as described, using reversal muxes around the shared left shifter.
- Not defined: req*_op is ignored and every job is SLL. The reversal and sign-fill logic is not instantiated.

## Test plan
- Reset, then req0 only: in=0x0000_0001, shamt=31, op=SLL. Expect handshake at t, rsp_valid at t+2, rsp_data=0x8000_0000, rsp_id=0.
- Both valid at once, rsp_ready=1, both held valid: first grant req0, second grant req1, third grant req0, each rsp_id matching. Check req0_ready and req1_ready are never both high.
- Back-pressure: hold rsp_ready=0 for 10 cycles in DONE. rsp_data stays stable, busy=1, both req_ready stay 0. Release: IDLE on the next edge, next grant one cycle later.
- With SHIFT_ARBITER_RIGHT_EN, in=0x8000_00F0, shamt=4: SRL → 0x0800_000F, SRA → 0xF800_000F. shamt=0 → 0x8000_00F0 for all ops.
- Without the macro: the same SRA job returns 0x0000_0F00 (SLL).
- Assert rst during SHIFT: the next cycle shows rsp_valid=0, rsp_data=0, busy=0. A tie afterwards grants req0.
